// File: rtl/wallace_pkg.sv
// Shared types and helpers for the pipelined Wallace multiplier family.
// Optional build macro used by the family: WALLACE_PERF_EN (output handshake counter).
package wallace_pkg;

   localparam int unsigned PIPE_DEPTH = 3;

   typedef struct packed {
      logic valid;
      logic neg;
   } stage_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   // Number of 3:2 carry-save levels needed to reduce 'rows' operands to two.
   function automatic int unsigned csa_levels(input int unsigned rows);
      int unsigned r;
      int unsigned l;
      r = rows;
      l = 0;
      while (r > 2) begin
         r = 2 * (r / 3) + (r % 3);
         l++;
      end
      return l;
   endfunction

endpackage

// File: rtl/wallace_half_mult.sv
// Combinational unsigned N x N Wallace-tree multiplier: partial-product rows are
// reduced by levels of 3:2 compressors down to two rows, then summed once.
module wallace_half_mult
   import wallace_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic [2*N-1:0] o_p
);

   localparam int unsigned PW     = 2 * N;
   localparam int unsigned LEVELS = csa_levels(N);
   localparam int unsigned GROUPS = N / 3;
   localparam int unsigned REST   = N % 3;

   logic [PW-1:0] w_a_ext;

   assign w_a_ext = {{N{1'b0}}, i_a};

   always_comb begin
      logic [PW-1:0] row [N];
      logic [PW-1:0] nxt [N];
      logic [PW-1:0] x, y, z;
      for (int r = 0; r < N; r++) begin
         row[r] = i_b[r] ? (w_a_ext << r) : '0;
         nxt[r] = '0;
      end
      // Rows past the live count are zero, so every level can sweep all N slots.
      for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
         for (int r = 0; r < N; r++) nxt[r] = '0;
         for (int g = 0; g < int'(GROUPS); g++) begin
            x = row[3*g];
            y = row[3*g+1];
            z = row[3*g+2];
            nxt[2*g]   = x ^ y ^ z;
            nxt[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
         end
         for (int k = 0; k < int'(REST); k++) begin
            nxt[2*GROUPS+k] = row[3*GROUPS+k];
         end
         for (int r = 0; r < N; r++) row[r] = nxt[r];
      end
      o_p = row[0] + row[1];
   end

endmodule

// File: rtl/wallace_mult_pipe.sv
// 3-stage signed/unsigned WIDTH x WIDTH multiplier built from four half-width Wallace
// multipliers; a single global advance stalls the whole pipe. WALLACE_PERF_EN adds op_count.
module wallace_mult_pipe
   import wallace_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p
`ifdef WALLACE_PERF_EN
   ,
   output logic [31:0]        op_count
`endif
);

   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned PW   = 2 * WIDTH;

   logic             w_adv;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

   stage_t           r_s1;
   logic [WIDTH-1:0] r_a_mag;
   logic [WIDTH-1:0] r_b_mag;

   logic [WIDTH-1:0] w_pp_ll, w_pp_hl, w_pp_lh, w_pp_hh;
   stage_t           r_s2;
   logic [WIDTH-1:0] r_pp_ll, r_pp_hl, r_pp_lh, r_pp_hh;

   logic [WIDTH:0]   w_mid;
   logic [PW-1:0]    w_mag;
   logic [PW-1:0]    w_prod;
   logic             r_out_valid;
   logic [PW-1:0]    r_out_p;

   assign w_adv     = !r_out_valid || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_out_valid;
   assign out_p     = r_out_p;

   // S1: sign/magnitude split; -2^(WIDTH-1) maps onto itself as an unsigned magnitude.
   assign w_a_neg = in_signed & in_a[WIDTH-1];
   assign w_b_neg = in_signed & in_b[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~in_a + WIDTH'(1)) : in_a;
   assign w_b_mag = w_b_neg ? (~in_b + WIDTH'(1)) : in_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= '0;
         r_a_mag <= '0;
         r_b_mag <= '0;
      end else if (w_adv) begin
         r_s1.valid <= in_valid;
         r_s1.neg   <= w_a_neg ^ w_b_neg;
         r_a_mag    <= w_a_mag;
         r_b_mag    <= w_b_mag;
      end
   end

   // S2: four half-width partial products.
   wallace_half_mult #(.N(HALF)) u_pp_ll (
      .i_a (r_a_mag[HALF-1:0]),
      .i_b (r_b_mag[HALF-1:0]),
      .o_p (w_pp_ll)
   );

   wallace_half_mult #(.N(HALF)) u_pp_hl (
      .i_a (r_a_mag[WIDTH-1:HALF]),
      .i_b (r_b_mag[HALF-1:0]),
      .o_p (w_pp_hl)
   );

   wallace_half_mult #(.N(HALF)) u_pp_lh (
      .i_a (r_a_mag[HALF-1:0]),
      .i_b (r_b_mag[WIDTH-1:HALF]),
      .o_p (w_pp_lh)
   );

   wallace_half_mult #(.N(HALF)) u_pp_hh (
      .i_a (r_a_mag[WIDTH-1:HALF]),
      .i_b (r_b_mag[WIDTH-1:HALF]),
      .o_p (w_pp_hh)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2    <= '0;
         r_pp_ll <= '0;
         r_pp_hl <= '0;
         r_pp_lh <= '0;
         r_pp_hh <= '0;
      end else if (w_adv) begin
         r_s2    <= r_s1;
         r_pp_ll <= w_pp_ll;
         r_pp_hl <= w_pp_hl;
         r_pp_lh <= w_pp_lh;
         r_pp_hh <= w_pp_hh;
      end
   end

   // S3: recombine; the cross-term sum needs one extra bit before shifting.
   assign w_mid  = {1'b0, r_pp_hl} + {1'b0, r_pp_lh};
   assign w_mag  = {r_pp_hh, {WIDTH{1'b0}}} + (PW'(w_mid) << HALF) + PW'(r_pp_ll);
   assign w_prod = r_s2.neg ? (~w_mag + PW'(1)) : w_mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_p     <= '0;
      end else if (w_adv) begin
         r_out_valid <= r_s2.valid;
         if (r_s2.valid) r_out_p <= w_prod;
      end
   end

`ifdef WALLACE_PERF_EN
   logic [31:0] r_op_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (r_out_valid && out_ready) begin
         r_op_count <= r_op_count + 32'd1;
      end
   end

   assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe (WIDTH=32): directed vectors, streaming,
// backpressure, mid-flight reset; op_count checks when WALLACE_PERF_EN is defined.
module tb_wallace_mult_pipe;

   localparam int unsigned WIDTH = 32;

   typedef struct {
      logic [63:0] p;
      int          cyc;
      bit          lat;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_signed = 1'b0;
   logic [WIDTH-1:0]  in_a = '0;
   logic [WIDTH-1:0]  in_b = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [2*WIDTH-1:0] out_p;
`ifdef WALLACE_PERF_EN
   logic [31:0]       op_count;
`endif

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   exp_t mon_e;
   bit   prev_stall = 0;
   logic [63:0] held_p;

   wallace_mult_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p)
`ifdef WALLACE_PERF_EN
      ,
      .op_count  (op_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake; checks holds while stalled.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!out_ready) begin
            check64("stall_in_ready", 64'(in_ready), 64'd0);
            if (prev_stall) check64("stall_out_p_hold", out_p, held_p);
            prev_stall = 1;
            held_p     = out_p;
         end else begin
            prev_stall = 0;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected no output", out_p);
            end else begin
               mon_e = q.pop_front();
               check64("product", out_p, mon_e.p);
               if (mon_e.lat) check64("latency", 64'(cyc - mon_e.cyc), 64'd2);
            end
         end
      end else begin
         prev_stall = 0;
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] p, input bit lat);
      int tries;
      bit ok;
      tries = 0;
      ok = 0;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      while (!ok && tries < 100) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         tries++;
      end
      #1;
      if (ok) begin
         q.push_back('{p: p, cyc: cyc, lat: lat});
      end else begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept in 100 cycles expected accept");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      check64("drain_pending", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check64("reset_out_valid", 64'(out_valid), 64'd0);
      check64("reset_in_ready", 64'(in_ready), 64'd1);
      check64("reset_out_p", out_p, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check64("post_reset_in_ready", 64'(in_ready), 64'd1);

      // Directed vectors.
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1);
      send(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1);
      send(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1);
      send(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
      send(32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1);
      send(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_0000, 1);
      send(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE, 1);
      send(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
      drain();

      // Back-to-back stream i*(i+1).
      for (int i = 0; i < 8; i++) begin
         send(32'(i), 32'(i + 1), 1'b0, 64'(i * (i + 1)), 1);
      end
      drain();

      // Backpressure window while five beats are in flight.
      fork
         begin
            for (int i = 0; i < 5; i++) send(32'(10 + i), 32'd3, 1'b0, 64'(3 * (10 + i)), 0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two beats in flight.
      out_ready = 1'b0;
      send(32'd3, 32'd3, 1'b0, 64'd9, 1);
      send(32'd4, 32'd4, 1'b0, 64'd16, 1);
      @(posedge clk);
      #2;
      check64("pre_reset_out_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check64("async_reset_out_valid", 64'(out_valid), 64'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      send(32'd7, 32'd6, 1'b0, 64'd42, 1);
      drain();

`ifdef WALLACE_PERF_EN
      for (int i = 0; i < 9; i++) send(32'(i + 1), 32'd1, 1'b0, 64'(i + 1), 1);
      drain();
      check64("op_count_ten", 64'(op_count), 64'd10);
      force dut.r_op_count = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.r_op_count;
      send(32'd2, 32'd2, 1'b0, 64'd4, 1);
      drain();
      check64("op_count_wrap", 64'(op_count), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
